// File: rtl/mem_pkg.sv
// Shared definitions for the data-memory access sequencer.
//   state_t            : sequencer states
//   *_BIT              : bit positions inside the one-hot access-size vector
//                        {memb, memh, lw, membu, memhu}
//   src_illegal()      : access size not one-hot, or a store with an
//                        unsigned load size
//   src_misaligned()   : memh on an odd byte, or lw off a word boundary
package mem_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RD,
    ST_RD_WAIT,
    ST_WR,
    ST_RESP
  } state_t;

  localparam int MEMB_BIT  = 4;
  localparam int MEMH_BIT  = 3;
  localparam int LW_BIT    = 2;
  localparam int MEMBU_BIT = 1;
  localparam int MEMHU_BIT = 0;

  function automatic logic src_illegal(input logic [4:0] src, input logic we);
    logic not_onehot;
    // x & (x-1) clears the lowest set bit; anything left means >1 bit set
    not_onehot = (src == 5'd0) || ((src & (src - 5'd1)) != 5'd0);
    return not_onehot || (we && (src[MEMBU_BIT] || src[MEMHU_BIT]));
  endfunction

  function automatic logic src_misaligned(input logic [4:0] src, input logic [1:0] lo);
    return (src[MEMH_BIT] && lo[0]) || (src[LW_BIT] && (lo != 2'b00));
  endfunction

endpackage

// File: rtl/mem_lane_merge.sv
// Byte-lane merge and load extraction for sub-word accesses.
//   src       in  5   one-hot access size {memb, memh, lw, membu, memhu}
//   lane      in  2   byte address bits [1:0]
//   wdata     in  16  right-aligned store data (only the low halfword is ever merged)
//   rword     in  32  word read from memory
//   merged    out 32  rword with the store byte/halfword inserted on its lane
//   extracted out 32  load result, sign- or zero-extended from the selected lane
// Halfword lanes use lane[1] only, so an odd halfword address lands on the
// naturally aligned halfword.
module mem_lane_merge
  import mem_pkg::*;
(
  input  logic [4:0]  src,
  input  logic [1:0]  lane,
  input  logic [15:0] wdata,
  input  logic [31:0] rword,
  output logic [31:0] merged,
  output logic [31:0] extracted
);

  logic [7:0]  rbyte;
  logic [15:0] rhalf;

  always_comb begin
    case (lane)
      2'd0:    rbyte = rword[7:0];
      2'd1:    rbyte = rword[15:8];
      2'd2:    rbyte = rword[23:16];
      default: rbyte = rword[31:24];
    endcase
    rhalf = lane[1] ? rword[31:16] : rword[15:0];

    merged = rword;
    if (src[MEMB_BIT]) begin
      case (lane)
        2'd0:    merged[7:0]   = wdata[7:0];
        2'd1:    merged[15:8]  = wdata[7:0];
        2'd2:    merged[23:16] = wdata[7:0];
        default: merged[31:24] = wdata[7:0];
      endcase
    end else if (src[MEMH_BIT]) begin
      if (lane[1]) merged[31:16] = wdata;
      else         merged[15:0]  = wdata;
    end

    extracted = rword;
    if (src[MEMB_BIT])       extracted = {{24{rbyte[7]}}, rbyte};
    else if (src[MEMBU_BIT]) extracted = {24'd0, rbyte};
    else if (src[MEMH_BIT])  extracted = {{16{rhalf[15]}}, rhalf};
    else if (src[MEMHU_BIT]) extracted = {16'd0, rhalf};
  end

endmodule

// File: rtl/mem_rmw_ctrl.sv
// Data-memory access sequencer: full-word stores go straight out, sub-word
// stores run as read-modify-write, loads are word reads returned
// lane-extracted. The pipeline is held off through busy for the whole access.
//   clk, rst_n                      clock, asynchronous active-low reset
//   req_valid/req_ready             request handshake from the pipeline
//   req_src/req_we/req_addr/req_wdata  access size (one-hot), store flag,
//                                   byte address, right-aligned store data
//   rsp_valid/rsp_rdata/rsp_err     one-cycle completion pulse, load data, error
//   busy                            high in every state except IDLE
//   mem_req/mem_we/mem_addr/mem_wdata  request to the word-wide memory
//   mem_gnt/mem_rvalid/mem_rdata    grant, read-data valid, read data
// Build option: define MEM_RMW_MISALIGN_TRAP_EN to reject misaligned memh/lw
// with rsp_err instead of silently aligning them.
module mem_rmw_ctrl
  import mem_pkg::*;
#(
  parameter int ADDR_W   = 32,
  parameter int WAIT_MAX = 15
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [4:0]        req_src,
  input  logic              req_we,
  input  logic [31:0]       req_addr,
  input  logic [31:0]       req_wdata,
  output logic              rsp_valid,
  output logic [31:0]       rsp_rdata,
  output logic              rsp_err,
  output logic              busy,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic              mem_gnt,
  input  logic              mem_rvalid,
  input  logic [31:0]       mem_rdata
);

  localparam int CNT_W = $clog2(WAIT_MAX + 1);
  // Last cycle of the wait window: counter runs 0 .. WAIT_MAX-1
  localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'(WAIT_MAX - 1);

  state_t           state;
  logic [4:0]       lat_src;
  logic             lat_we;
  logic [1:0]       lat_lo;
  logic [15:0]      lat_wdata;
  logic [CNT_W-1:0] wait_cnt;

  logic              accept;
  logic              illegal_req;
  logic [ADDR_W+1:0] addr_ext;
  logic [31:0]       merged_word;
  logic [31:0]       load_word;

  assign accept   = req_valid && req_ready;
  // Zero-extend so the word-address slice is legal for any ADDR_W
  assign addr_ext = (ADDR_W + 2)'(req_addr);

  always_comb begin
    illegal_req = src_illegal(req_src, req_we);
`ifdef MEM_RMW_MISALIGN_TRAP_EN
    illegal_req = illegal_req || src_misaligned(req_src, req_addr[1:0]);
`endif
  end

  mem_lane_merge u_merge (
    .src       (lat_src),
    .lane      (lat_lo),
    .wdata     (lat_wdata),
    .rword     (mem_rdata),
    .merged    (merged_word),
    .extracted (load_word)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      lat_src   <= '0;
      lat_we    <= 1'b0;
      lat_lo    <= '0;
      lat_wdata <= '0;
      wait_cnt  <= '0;
      req_ready <= 1'b1;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
      busy      <= 1'b0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (accept) begin
            lat_src   <= req_src;
            lat_we    <= req_we;
            lat_lo    <= req_addr[1:0];
            lat_wdata <= req_wdata[15:0];
            mem_addr  <= addr_ext[ADDR_W+1:2];
            req_ready <= 1'b0;
            busy      <= 1'b1;
            if (illegal_req) begin
              rsp_valid <= 1'b1;
              rsp_err   <= 1'b1;
              rsp_rdata <= '0;
              state     <= ST_RESP;
            end else if (req_we && req_src[LW_BIT]) begin
              mem_req   <= 1'b1;
              mem_we    <= 1'b1;
              mem_wdata <= req_wdata;
              state     <= ST_WR;
            end else begin
              mem_req <= 1'b1;
              mem_we  <= 1'b0;
              state   <= ST_RD;
            end
          end
        end

        ST_RD: begin
          if (mem_gnt) begin
            mem_req  <= 1'b0;
            wait_cnt <= '0;
            state    <= ST_RD_WAIT;
          end
        end

        ST_RD_WAIT: begin
          if (mem_rvalid) begin
            if (lat_we) begin
              mem_wdata <= merged_word;
              mem_req   <= 1'b1;
              mem_we    <= 1'b1;
              state     <= ST_WR;
            end else begin
              rsp_rdata <= load_word;
              rsp_valid <= 1'b1;
              state     <= ST_RESP;
            end
          end else if (wait_cnt == WAIT_LAST) begin
            // Memory never answered: abandon, report, and skip any write-back
            rsp_rdata <= '0;
            rsp_err   <= 1'b1;
            rsp_valid <= 1'b1;
            state     <= ST_RESP;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end

        ST_WR: begin
          if (mem_gnt) begin
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            rsp_rdata <= '0;
            rsp_valid <= 1'b1;
            state     <= ST_RESP;
          end
        end

        ST_RESP: begin
          rsp_valid <= 1'b0;
          rsp_err   <= 1'b0;
          rsp_rdata <= '0;
          busy      <= 1'b0;
          req_ready <= 1'b1;
          state     <= ST_IDLE;
        end

        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_rmw_ctrl.sv
// Self-checking bench for mem_rmw_ctrl: a word memory with programmable
// grant / read-latency behaviour, a reference model of each access, directed
// cases and a randomized run.
module tb_mem_rmw_ctrl;

  localparam int WAIT_MAX = 15;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [4:0]  req_src = '0;
  logic        req_we = 1'b0;
  logic [31:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic        busy;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_gnt = 1'b0;
  logic        mem_rvalid = 1'b0;
  logic [31:0] mem_rdata = '0;

  mem_rmw_ctrl #(.ADDR_W(32), .WAIT_MAX(WAIT_MAX)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_src    (req_src),
    .req_we     (req_we),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .rsp_valid  (rsp_valid),
    .rsp_rdata  (rsp_rdata),
    .rsp_err    (rsp_err),
    .busy       (busy),
    .mem_req    (mem_req),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_gnt    (mem_gnt),
    .mem_rvalid (mem_rvalid),
    .mem_rdata  (mem_rdata)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
    end
  endtask

  // ---------------- memory responder ----------------
  logic [31:0] mem [0:255];
  int          gnt_delay = 0;
  int          rv_delay  = 0;
  int          req_age = 0;
  bit          rd_pend = 0;
  int          rd_age = 0;
  logic [31:0] rd_word = '0;
  int          wr_cnt = 0, rd_cnt = 0, req_seen = 0, addr_viol = 0;
  logic [31:0] wr_addr = '0, wr_data = '0;
  bit          prev_wait = 0;
  logic [31:0] prev_addr = '0;

  always @(posedge clk) begin
    if (mem_rvalid) rd_pend = 0;
    else if (rd_pend) rd_age++;
    if (mem_req) req_seen++;
    if (mem_req && prev_wait && (mem_addr != prev_addr)) addr_viol++;
    if (mem_req && mem_gnt) begin
      if (mem_we) begin
        wr_cnt++;
        wr_addr = mem_addr;
        wr_data = mem_wdata;
      end else begin
        rd_cnt++;
        rd_pend = 1;
        rd_age  = 0;
        rd_word = mem[mem_addr[7:0]];
      end
      req_age   = 0;
      prev_wait = 0;
    end else if (mem_req) begin
      req_age++;
      prev_wait = 1;
      prev_addr = mem_addr;
    end else begin
      req_age   = 0;
      prev_wait = 0;
    end
  end

  always @(negedge clk) begin
    mem_gnt = mem_req && (req_age >= gnt_delay);
    if (rd_pend && rv_delay >= 0 && rd_age >= rv_delay) begin
      mem_rvalid = 1'b1;
      mem_rdata  = rd_word;
    end else begin
      mem_rvalid = 1'b0;
      mem_rdata  = $urandom;
    end
  end

  // ---------------- reference model ----------------
  function automatic void ref_model(input logic [4:0] src, input logic we,
                                    input logic [31:0] addr, input logic [31:0] wdata,
                                    input logic [31:0] word, output logic err,
                                    output logic [31:0] rdata, output logic wr,
                                    output logic [31:0] wword);
    int k, h;
    logic [31:0] b, hw;
    k  = int'(addr % 4);
    h  = int'((addr / 2) % 2);
    b  = (word >> (8 * k)) & 32'hFF;
    hw = (word >> (16 * h)) & 32'hFFFF;
    err = ($countones(src) != 1) || (we && (src[1] || src[0]));
`ifdef MEM_RMW_MISALIGN_TRAP_EN
    if (src[3] && addr[0]) err = 1'b1;
    if (src[2] && (addr % 4) != 0) err = 1'b1;
`endif
    rdata = '0;
    wr    = 1'b0;
    wword = '0;
    if (err) return;
    if (!we) begin
      if (src[4])      rdata = (b >= 128) ? b - 32'd256 : b;
      else if (src[3]) rdata = (hw >= 32768) ? hw - 32'd65536 : hw;
      else if (src[2]) rdata = word;
      else if (src[1]) rdata = b;
      else             rdata = hw;
    end else begin
      wr = 1'b1;
      if (src[4])      wword = (word & ~(32'hFF << (8 * k))) | ((wdata & 32'hFF) << (8 * k));
      else if (src[3]) wword = (word & ~(32'hFFFF << (16 * h))) | ((wdata & 32'hFFFF) << (16 * h));
      else             wword = wdata;
    end
  endfunction

  logic [31:0] last_rdata = '0;

  task automatic do_txn(input string tag, input logic [4:0] src, input logic we,
                        input logic [31:0] addr, input logic [31:0] wdata,
                        input int gd, input int rv);
    logic [31:0] word, exp_rd, exp_ww;
    logic        exp_err, exp_wr;
    bit          tmo, got, ctl_bad;
    int          wr0, rd0, rq0, av0, cyc, exp_lat;
    word = mem[addr[9:2]];
    ref_model(src, we, addr, wdata, word, exp_err, exp_rd, exp_wr, exp_ww);
    if (exp_err)              exp_lat = 1;
    else if (we && src[2])    exp_lat = 2 + gd;
    else if (!we)             exp_lat = 3 + gd + rv;
    else                      exp_lat = 4 + 2 * gd + rv;
    tmo = !exp_err && !(we && src[2]) && (rv < 0);
    if (tmo) begin
      exp_err = 1'b1;
      exp_wr  = 1'b0;
      exp_rd  = '0;
    end
    gnt_delay = gd;
    rv_delay  = rv;
    wr0 = wr_cnt; rd0 = rd_cnt; rq0 = req_seen; av0 = addr_viol;
    got = 0; ctl_bad = 0;
    @(negedge clk);
    chk({tag, "/ready"}, 32'(req_ready), 32'd1);
    req_valid = 1'b1;
    req_src   = src;
    req_we    = we;
    req_addr  = addr;
    req_wdata = wdata;
    @(negedge clk);
    req_valid = 1'b0;
    cyc = 1;
    while (cyc < 200) begin
      if (rsp_valid) begin
        got = 1;
        break;
      end
      if (!busy || req_ready) ctl_bad = 1;
      @(negedge clk);
      cyc++;
    end
    chk({tag, "/rsp_seen"}, 32'(got), 32'd1);
    if (got) begin
      if (!tmo) chk({tag, "/latency"}, 32'(cyc), 32'(exp_lat));
      chk({tag, "/err"}, 32'(rsp_err), 32'(exp_err));
      chk({tag, "/rdata"}, rsp_rdata, exp_rd);
      chk({tag, "/resp_ready_busy"}, {30'd0, req_ready, busy}, 32'b01);
      last_rdata = rsp_rdata;
    end
    chk({tag, "/ctl_wait"}, 32'(ctl_bad), 32'd0);
    chk({tag, "/writes"}, 32'(wr_cnt - wr0), 32'(exp_wr));
    if (exp_wr) begin
      chk({tag, "/wr_addr"}, wr_addr, addr >> 2);
      chk({tag, "/wr_data"}, wr_data, exp_ww);
      mem[addr[9:2]] = exp_ww;
    end
    if (exp_err && !tmo) chk({tag, "/no_mem_req"}, 32'(req_seen - rq0), 32'd0);
    chk({tag, "/addr_stable"}, 32'(addr_viol - av0), 32'd0);
    @(negedge clk);
    chk({tag, "/idle"}, {29'd0, rsp_valid, busy, req_ready}, 32'b001);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int wr0;
    bit bad;
    for (int i = 0; i < 256; i++) mem[i] = $urandom;

    repeat (3) @(negedge clk);
    chk("rst/ready", 32'(req_ready), 32'd1);
    chk("rst/ctl", {26'd0, rsp_valid, rsp_err, busy, mem_req, mem_we, 1'b0}, 32'd0);
    chk("rst/rdata", rsp_rdata, 32'd0);
    chk("rst/mem_addr", mem_addr, 32'd0);
    chk("rst/mem_wdata", mem_wdata, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    mem[8'h40] = 32'h11223344;
    do_txn("sb_rmw", 5'b10000, 1'b1, 32'h102, 32'h000000AB, 0, 0);
    chk("sb_rmw/word", wr_data, 32'h11AB3344);

    mem[8'h01] = 32'hAAAAAAAA;
    do_txn("sh_gnt3", 5'b01000, 1'b1, 32'h6, 32'h0000BEEF, 3, 0);
    chk("sh_gnt3/word", wr_data, 32'hBEEFAAAA);

    mem[8'h00] = 32'h80FFFFFF;
    do_txn("lb", 5'b10000, 1'b0, 32'h3, 32'h0, 0, 0);
    chk("lb/value", last_rdata, 32'hFFFFFF80);
    do_txn("lbu", 5'b00010, 1'b0, 32'h3, 32'h0, 0, 0);
    chk("lbu/value", last_rdata, 32'h00000080);

    do_txn("lw_tmo", 5'b00100, 1'b0, 32'h10, 32'h0, 0, -1);
    do_txn("sw", 5'b00100, 1'b1, 32'h24, 32'hCAFEF00D, 0, 0);
    do_txn("illegal", 5'b11000, 1'b0, 32'h40, 32'h0, 0, 0);
    do_txn("st_unsigned", 5'b00001, 1'b1, 32'h44, 32'h1234, 0, 0);

    // Reset while the sb read is outstanding; its data shows up afterwards
    gnt_delay = 0;
    rv_delay  = 4;
    wr0 = wr_cnt;
    bad = 0;
    @(negedge clk);
    req_valid = 1'b1; req_src = 5'b10000; req_we = 1'b1;
    req_addr = 32'h20; req_wdata = 32'h55;
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_mid/ready", 32'(req_ready), 32'd1);
    chk("rst_mid/ctl", {27'd0, rsp_valid, rsp_err, busy, mem_req, mem_we}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (8) begin
      @(negedge clk);
      if (rsp_valid || busy || mem_req) bad = 1;
    end
    chk("rst_mid/quiet", 32'(bad), 32'd0);
    chk("rst_mid/no_write", 32'(wr_cnt - wr0), 32'd0);
    do_txn("sw_after_rst", 5'b00100, 1'b1, 32'h28, 32'h0BADBEEF, 0, 0);

    for (int i = 0; i < 60; i++) begin
      logic [4:0] src;
      src = 5'b00001 << $urandom_range(0, 4);
      if ($urandom_range(0, 9) == 0) src = 5'($urandom);
      do_txn($sformatf("rnd%0d", i), src, 1'($urandom_range(0, 1)),
             32'($urandom_range(0, 1023)), $urandom,
             int'($urandom_range(0, 2)), int'($urandom_range(0, 3)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_rmw_ctrl.md
Name: mem_rmw_ctrl

Overview:
- Multi-cycle data-memory access sequencer between the execute/memory stage and a single-port, word-wide data memory with a req/gnt/rvalid handshake.
- Full-word stores (sw) are issued directly.
- Sub-word stores (sb/sh) are run as read-modify-write. The read word is merged with the store data on the correct byte lane, then written back.
- Loads (lb/lh/lw/lbu/lhu) are issued as word reads and returned lane-extracted and extended. The pipeline is stalled through busy.

Parameters:
- ADDR_W, 32, memory word-address width; mem_addr = req_addr[ADDR_W+1:2].
- WAIT_MAX, 15, maximum cycles spent waiting for mem_rvalid before a bus-error response.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  1  access request from the pipeline.
- req_ready  out  1  request accepted when req_valid & req_ready.
- req_src  in  5  one-hot access size {memb, memh, lw, membu, memhu}.
- req_we  in  1  1 = store, 0 = load.
- req_addr  in  32  byte address.
- req_wdata  in  32  store data, right-aligned.
- rsp_valid  out  1  one-cycle completion pulse.
- rsp_rdata  out  32  load result; 0 for stores.
- rsp_err  out  1  qualified by rsp_valid: timeout or illegal request.
- busy  out  1  stall to pipeline; high in every state except IDLE.
- mem_req  out  1  memory request.
- mem_we  out  1  memory write enable.
- mem_addr  out  ADDR_W  memory word address.
- mem_wdata  out  32  memory write data.
- mem_gnt  in  1  request accepted this cycle.
- mem_rvalid  in  1  read data valid; never earlier than the cycle after gnt.
- mem_rdata  in  32  read data.

Behaviour:
- Reset (asynchronous, rst_n low):
  - state = IDLE; all outputs 0 except req_ready = 1.
  - Latched request registers and the wait counter are cleared.
  - Reset mid-transaction abandons the access, with no write issued. Any mem_rvalid arriving afterwards in IDLE is ignored.
- States: IDLE, RD, RD_WAIT, WR, RESP.
- IDLE:
  - req_ready = 1. On accept, latch src, we, addr and wdata.
  - Illegal request goes to RESP with rsp_err = 1. Illegal means req_src not one-hot, or req_we with membu/memhu.
  - Store lw goes to WR. Any other access goes to RD.
- RD:
  - mem_req = 1, mem_we = 0; hold until mem_gnt, then go to RD_WAIT and clear the wait counter.
- RD_WAIT:
  - The counter increments each cycle.
  - On mem_rvalid:
    - Load: register the extracted result and go to RESP.
    - Store: register the merged word and go to WR.
  - Counter reaches WAIT_MAX without rvalid: go to RESP with rsp_err = 1 and no write.
- WR:
  - mem_req = 1, mem_we = 1; mem_wdata is the merged word, or req_wdata for lw.
  - Hold until mem_gnt, then go to RESP.
- RESP:
  - rsp_valid = 1 for exactly one cycle, then IDLE. req_ready stays 0 in this cycle.
- Merge rules:
  - memb: lane addr[1:0]; byte k of the read word is replaced by wdata[7:0].
  - memh: lane addr[1]; halfword replaced by wdata[15:0]. All other bytes are preserved.
- Load extraction: memb/memh sign-extend; membu/memhu zero-extend; lw returns the word.
- mem_addr is constant while mem_req is held without gnt.
- Minimum latency (accept cycle = 0, zero-wait memory):
  - sw: rsp at cycle 2.
  - loads: rsp at cycle 3.
  - sb/sh: rsp at cycle 4.

Optional Feature:
- MEM_RMW_MISALIGN_TRAP_EN defined: memh with addr[0] = 1, or lw with addr[1:0] != 0, is illegal. It goes IDLE -> RESP with rsp_err = 1 and no memory access.
- Not defined: low address bits below the access size are ignored and the access is forced to natural alignment.

Decomposition:
- Shared package mem_pkg:
  - state enum.
  - MemSrc one-hot bit-index constants (MEMB_BIT = 4 … MEMHU_BIT = 0).
  - illegal-src helper function.
- Natural sub-module: mem_lane_merge. Purely combinational merge plus load-extract on the byte lane; it generalises the existing write-data select to all four lanes.

Test Plan:
- sb, addr 0x102, wdata 0x000000AB; memory word at 0x40 = 0x11223344, zero wait -> write 0x11AB3344 at word 0x40, rsp at cycle 4, err = 0.
- sh, addr 0x6, wdata 0xBEEF; word = 0xAAAAAAAA; gnt delayed 3 cycles in RD -> write 0xBEEFAAAA, mem_addr stable while waiting.
- lb, addr 0x3, word 0x80FFFFFF -> rsp_rdata 0xFFFFFF80. lbu at the same address -> 0x00000080.
- lw load, mem_rvalid withheld for WAIT_MAX cycles -> rsp_err = 1, no write issued, FSM back in IDLE.
- req_src = 5'b11000 -> rsp_err = 1 at cycle 1, mem_req never asserted.
- rst_n low during RD_WAIT of sb -> outputs reset immediately, no WR. Late rvalid is ignored; the next sw completes normally.
